// File: rtl/frame_buffer_arbiter.sv
// Frame-buffer RAM arbiter: scan-out reads, background fill sequencer and game
// pixel writes share one single-port RAM, granted in that priority order.
module frame_buffer_arbiter #(
    parameter int unsigned H_FRAME   = 160,
    parameter int unsigned V_FRAME   = 120,
    parameter int unsigned GRASS_PCT = 25,
    parameter int unsigned ADDR_W    = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    output logic              busy,
    output logic              fill_done,
    input  logic              rd_req,
    input  logic [15:0]       rd_row,
    input  logic [15:0]       rd_col,
    output logic              rd_valid,
    output logic [11:0]       rd_pixel,
    input  logic              wr_req,
    input  logic [15:0]       wr_row,
    input  logic [15:0]       wr_col,
    input  logic [11:0]       wr_pixel,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [11:0]       mem_wdata,
    input  logic [11:0]       mem_rdata
);

    localparam int unsigned COL_W   = (H_FRAME > 1) ? $clog2(H_FRAME) : 1;
    localparam int unsigned ROW_W   = (V_FRAME > 1) ? $clog2(V_FRAME) : 1;
    localparam int unsigned GRASS_T = V_FRAME * GRASS_PCT / 100;

    localparam logic [11:0] COLOUR_GREEN = 12'h0F0;
    localparam logic [11:0] COLOUR_BLUE  = 12'h00F;

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [ROW_W-1:0] fill_row_q, fill_row_d;
    logic [COL_W-1:0] fill_col_q, fill_col_d;
    logic             fill_done_q, fill_done_d;
    logic             rd_valid_q;
    logic             rd_oob_q;

    logic              rd_in_range;
    logic              wr_in_range;
    logic              fill_last;
    logic              fill_grant;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] fill_addr;
    logic [11:0]       fill_colour;

    // Coordinate decode; addresses are row-major and truncated to the RAM width
    assign rd_in_range = (32'(rd_row) < V_FRAME) && (32'(rd_col) < H_FRAME);
    assign wr_in_range = (32'(wr_row) < V_FRAME) && (32'(wr_col) < H_FRAME);
    assign rd_addr     = ADDR_W'(32'(rd_row) * H_FRAME + 32'(rd_col));
    assign wr_addr     = ADDR_W'(32'(wr_row) * H_FRAME + 32'(wr_col));
    assign fill_addr   = ADDR_W'(32'(fill_row_q) * H_FRAME + 32'(fill_col_q));
    assign fill_colour = (32'(fill_row_q) <= GRASS_T) ? COLOUR_GREEN : COLOUR_BLUE;
    assign fill_last   = (fill_row_q == ROW_W'(V_FRAME - 1)) &&
                         (fill_col_q == COL_W'(H_FRAME - 1));

    // One grant per cycle: read, then fill, then game write
    always_comb begin
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        wr_ack     = 1'b0;
        fill_grant = 1'b0;
        if (rd_req) begin
            // an out-of-range read still consumes the slot
            mem_en   = rd_in_range;
            mem_addr = rd_addr;
        end else if (state_q == S_FILL) begin
            fill_grant = 1'b1;
            mem_en     = 1'b1;
            mem_we     = 1'b1;
            mem_addr   = fill_addr;
            mem_wdata  = fill_colour;
        end else if (wr_req) begin
            wr_ack    = 1'b1;
            mem_en    = wr_in_range;
            mem_we    = wr_in_range;
            mem_addr  = wr_addr;
            mem_wdata = wr_pixel;
        end
        if (!rst_n) begin
            mem_en     = 1'b0;
            mem_we     = 1'b0;
            wr_ack     = 1'b0;
            fill_grant = 1'b0;
        end
    end

    // Fill sequencer next state; clear_req overrides completion
    always_comb begin
        state_d     = state_q;
        fill_row_d  = fill_row_q;
        fill_col_d  = fill_col_q;
        fill_done_d = 1'b0;
        if (fill_grant) begin
            if (fill_last) begin
                state_d     = S_RUN;
                fill_row_d  = '0;
                fill_col_d  = '0;
                fill_done_d = 1'b1;
            end else if (fill_col_q == COL_W'(H_FRAME - 1)) begin
                fill_col_d = '0;
                fill_row_d = fill_row_q + ROW_W'(1);
            end else begin
                fill_col_d = fill_col_q + COL_W'(1);
            end
        end
        if (clear_req) begin
            state_d     = S_FILL;
            fill_row_d  = '0;
            fill_col_d  = '0;
            fill_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_FILL;
            fill_row_q  <= '0;
            fill_col_q  <= '0;
            fill_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_oob_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_row_q  <= fill_row_d;
            fill_col_q  <= fill_col_d;
            fill_done_q <= fill_done_d;
            rd_valid_q  <= rd_req;
            rd_oob_q    <= rd_req && !rd_in_range;
        end
    end

    assign busy      = (state_q == S_FILL) || !rst_n;
    assign fill_done = fill_done_q;
    assign rd_valid  = rd_valid_q;
    assign rd_pixel  = (rst_n && rd_valid_q && !rd_oob_q) ? mem_rdata : 12'h000;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Bench for frame_buffer_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a pixel-index reference model of the frame buffer.
module tb_frame_buffer_arbiter;

    localparam int unsigned H    = 8;
    localparam int unsigned V    = 4;
    localparam int unsigned G    = 50;
    localparam int unsigned AW   = 5;
    localparam int unsigned NPIX = H * V;
    localparam int unsigned T    = V * G / 100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear_req;
    logic          busy;
    logic          fill_done;
    logic          rd_req;
    logic [15:0]   rd_row;
    logic [15:0]   rd_col;
    logic          rd_valid;
    logic [11:0]   rd_pixel;
    logic          wr_req;
    logic [15:0]   wr_row;
    logic [15:0]   wr_col;
    logic [11:0]   wr_pixel;
    logic          wr_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [11:0]   mem_wdata;
    logic [11:0]   mem_rdata;

    frame_buffer_arbiter #(
        .H_FRAME  (H),
        .V_FRAME  (V),
        .GRASS_PCT(G),
        .ADDR_W   (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_req(clear_req),
        .busy     (busy),
        .fill_done(fill_done),
        .rd_req   (rd_req),
        .rd_row   (rd_row),
        .rd_col   (rd_col),
        .rd_valid (rd_valid),
        .rd_pixel (rd_pixel),
        .wr_req   (wr_req),
        .wr_row   (wr_row),
        .wr_col   (wr_col),
        .wr_pixel (wr_pixel),
        .wr_ack   (wr_ack),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM with synchronous read
    logic [11:0] ram [NPIX];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Reference model: frame contents plus fill progress as a linear pixel index
    logic [11:0] ref_ram [NPIX];
    bit          m_fill;
    int unsigned m_pos;
    bit          m_rd_pend;
    bit          m_rd_oob;
    logic [11:0] m_rd_data;
    bit          m_done;

    int n_vec = 0;
    int n_err = 0;
    int done_seen = 0;
    logic obs_busy, obs_done, obs_ack, obs_valid, obs_en;
    logic [11:0] obs_pix;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_rng(input logic [15:0] r, input logic [15:0] c);
        return (r < 16'(V)) && (c < 16'(H));
    endfunction

    function automatic logic [11:0] bg_colour(input int unsigned pos);
        return (pos / H <= T) ? 12'h0F0 : 12'h00F;
    endfunction

    // One clock: check outputs at negedge against the model, then advance it
    task automatic cycle();
        bit          exp_en, exp_we, exp_ack;
        int unsigned exp_addr;
        logic [11:0] exp_wd;
        @(negedge clk);
        obs_busy  = busy;
        obs_done  = fill_done;
        obs_ack   = wr_ack;
        obs_valid = rd_valid;
        obs_pix   = rd_pixel;
        obs_en    = mem_en;
        if (fill_done === 1'b1 && rst_n) done_seen++;
        exp_en = 0; exp_we = 0; exp_ack = 0; exp_addr = 0; exp_wd = 12'h000;
        if (!rst_n) begin
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_wr_ack", wr_ack, 0);
            chk("rst_rd_pixel", rd_pixel, 0);
            chk("rst_busy", busy, 1);
        end else begin
            if (rd_req) begin
                exp_en   = in_rng(rd_row, rd_col);
                exp_addr = int'(rd_row) * H + int'(rd_col);
            end else if (m_fill) begin
                exp_en   = 1; exp_we = 1;
                exp_addr = m_pos;
                exp_wd   = bg_colour(m_pos);
            end else if (wr_req) begin
                exp_ack  = 1;
                exp_en   = in_rng(wr_row, wr_col);
                exp_we   = exp_en;
                exp_addr = int'(wr_row) * H + int'(wr_col);
                exp_wd   = wr_pixel;
            end
            chk("busy", busy, m_fill);
            chk("fill_done", fill_done, m_done);
            chk("rd_valid", rd_valid, m_rd_pend);
            chk("rd_pixel", rd_pixel, (m_rd_pend && !m_rd_oob) ? m_rd_data : 12'h000);
            chk("mem_en", mem_en, exp_en);
            chk("wr_ack", wr_ack, exp_ack);
            if (exp_en) begin
                chk("mem_we", mem_we, exp_we);
                chk("mem_addr", mem_addr, exp_addr);
                if (exp_we) chk("mem_wdata", mem_wdata, exp_wd);
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            m_fill = 1; m_pos = 0; m_rd_pend = 0; m_rd_oob = 0; m_done = 0;
        end else begin
            m_done    = 0;
            m_rd_pend = rd_req;
            m_rd_oob  = rd_req && !in_rng(rd_row, rd_col);
            if (rd_req && in_rng(rd_row, rd_col))
                m_rd_data = ref_ram[int'(rd_row) * H + int'(rd_col)];
            if (!rd_req && m_fill) begin
                ref_ram[m_pos] = bg_colour(m_pos);
                if (m_pos == NPIX - 1) begin
                    m_fill = 0; m_pos = 0; m_done = 1;
                end else begin
                    m_pos++;
                end
            end else if (!rd_req && wr_req && in_rng(wr_row, wr_col)) begin
                ref_ram[int'(wr_row) * H + int'(wr_col)] = wr_pixel;
            end
            if (clear_req) begin
                m_fill = 1; m_pos = 0; m_done = 0;
            end
        end
        #1;
    endtask

    task automatic pulse_clear();
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
    endtask

    task automatic check_background(input string tag);
        for (int p = 0; p < int'(NPIX); p++)
            chk(tag, ram[p], (p < 24) ? 12'h0F0 : 12'h00F);
    endtask

    initial begin
        int cnt, idx, done_base;
        for (int p = 0; p < int'(NPIX); p++) begin
            ram[p] = 12'h000;
            ref_ram[p] = 12'h000;
        end
        mem_rdata = 12'h000;
        m_rd_data = 12'h000;
        rst_n = 1'b0; clear_req = 1'b0;
        rd_req = 1'b0; rd_row = '0; rd_col = '0;
        wr_req = 1'b0; wr_row = '0; wr_col = '0; wr_pixel = '0;
        m_fill = 1; m_pos = 0; m_rd_pend = 0; m_rd_oob = 0; m_done = 0;
        repeat (3) cycle();
        rst_n = 1'b1;

        // Fill after reset release
        cnt = 0; done_base = done_seen;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (!obs_busy) break;
            cnt++;
        end
        repeat (4) cycle();
        chk("s1_busy_cycles", cnt, 32);
        chk("s1_done_count", done_seen - done_base, 1);
        check_background("s1_ram");

        // Fill with reads on alternate cycles for the first 32 cycles
        pulse_clear();
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            rd_req = (i < 32) && (i % 2 == 0);
            rd_row = 16'($urandom_range(0, V - 1));
            rd_col = 16'($urandom_range(0, H - 1));
            cycle();
            if (!obs_busy) break;
            cnt++;
        end
        rd_req = 1'b0;
        chk("s2_fill_cycles", cnt, 48);
        check_background("s2_ram");

        // Writer stalls through a fill, acked in the first RUN cycle
        pulse_clear();
        wr_req = 1'b1; wr_row = 16'd1; wr_col = 16'd3; wr_pixel = 12'hF00;
        idx = -1;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (obs_ack) begin idx = i; break; end
        end
        chk("s3_ack_cycle", idx, 32);
        chk("s3_busy_at_ack", obs_busy, 0);
        wr_req = 1'b0;
        cycle();
        chk("s3_ram11", ram[11], 12'hF00);

        // Reads beat the writer; ack after reads drop
        wr_req = 1'b1; wr_row = 16'd2; wr_col = 16'd5; wr_pixel = 12'h0AB;
        idx = -1;
        for (int i = 0; i < 10; i++) begin
            rd_req = (i < 3);
            rd_row = 16'(i); rd_col = 16'(i + 1);
            cycle();
            if (obs_ack) begin idx = i; break; end
        end
        rd_req = 1'b0; wr_req = 1'b0;
        chk("s4_ack_cycle", idx, 3);

        // Out-of-range read and write
        rd_req = 1'b1; rd_row = 16'd5; rd_col = 16'd0;
        cycle();
        chk("s5_oob_rd_en", obs_en, 0);
        rd_req = 1'b0;
        cycle();
        chk("s5_oob_rd_valid", obs_valid, 1);
        chk("s5_oob_rd_pixel", obs_pix, 12'h000);
        wr_req = 1'b1; wr_row = 16'd0; wr_col = 16'd9; wr_pixel = 12'hFFF;
        cycle();
        chk("s5_oob_wr_ack", obs_ack, 1);
        chk("s5_oob_wr_en", obs_en, 0);
        wr_req = 1'b0;
        cycle();
        for (int p = 0; p < int'(NPIX); p++) chk("s5_ram", ram[p], ref_ram[p]);

        // Clear at pixel 20, reset at pixel 10 of the restart
        done_base = done_seen;
        pulse_clear();
        repeat (20) cycle();
        pulse_clear();
        repeat (10) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        idx = -1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (obs_done && idx < 0) idx = i;
        end
        chk("s6_done_cycle", idx, 32);
        chk("s6_done_count", done_seen - done_base, 1);
        check_background("s6_ram");

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            rd_req    = ($urandom_range(0, 2) == 0);
            rd_row    = 16'($urandom_range(0, 5));
            rd_col    = 16'($urandom_range(0, 9));
            clear_req = ($urandom_range(0, 96) == 0);
            rst_n     = ($urandom_range(0, 250) != 0);
            if (!wr_req && $urandom_range(0, 1) == 1) begin
                wr_req   = 1'b1;
                wr_row   = 16'($urandom_range(0, 5));
                wr_col   = 16'($urandom_range(0, 9));
                wr_pixel = 12'($urandom);
            end
            cycle();
            if (obs_ack) wr_req = 1'b0;
        end
        rst_n = 1'b1; rd_req = 1'b0; clear_req = 1'b0; wr_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (!obs_busy) break;
            cnt++;
        end
        chk("rand_fill_bounded", (cnt < 200) ? 1 : 0, 1);
        for (int p = 0; p < int'(NPIX); p++) chk("rand_ram", ram[p], ref_ram[p]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
